// File: rtl/dcache_pkg.sv
// Shared state encoding and geometry helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    localparam int unsigned BYTE_OFF_W = 2;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    function automatic int unsigned woff_width(input int unsigned block_words);
        return $clog2(block_words);
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned num_sets,
                                              input int unsigned block_words);
        return addr_w - BYTE_OFF_W - idx_width(num_sets) - woff_width(block_words);
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        logic [3:0] be;
        case (lane)
            LANE_0:  be = 4'b0001;
            LANE_1:  be = 4'b0010;
            LANE_2:  be = 4'b0100;
            LANE_3:  be = 4'b1000;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            LANE_0:  b = word[7:0];
            LANE_1:  b = word[15:8];
            LANE_2:  b = word[23:16];
            LANE_3:  b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Line data storage: one asynchronous read port and one byte-masked synchronous write port.
module dcache_data_array
    import dcache_pkg::*;
#(
    parameter int unsigned  NUM_SETS    = 256,
    parameter int unsigned  BLOCK_WORDS = 4,
    localparam int unsigned IDX_W       = idx_width(NUM_SETS),
    localparam int unsigned WOFF_W      = woff_width(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  rd_set_i,
    input  logic [WOFF_W-1:0] rd_word_i,
    output logic [31:0]       rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_set_i,
    input  logic [WOFF_W-1:0] wr_word_i,
    input  logic [3:0]        wr_be_i,
    input  logic [31:0]       wr_data_i
);

    logic [31:0] data_q [NUM_SETS*BLOCK_WORDS];

    assign rd_data_o = data_q[{rd_set_i, rd_word_i}];

    // Byte-masked write; contents are intentionally not reset, validity lives in the controller.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en_i && wr_be_i[b]) begin
                data_q[{wr_set_i, wr_word_i}][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache with zero-latency hits and a
// word-serial write-back/refill engine toward the backing memory.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_SETS    = 256,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned       WOFF_W    = woff_width(BLOCK_WORDS);
    localparam int unsigned       IDX_W     = idx_width(NUM_SETS);
    localparam int unsigned       TAG_W     = tag_width(ADDR_W, NUM_SETS, BLOCK_WORDS);
    localparam logic [WOFF_W-1:0] WORD_ZERO = {WOFF_W{1'b0}};
    localparam logic [WOFF_W-1:0] WORD_ONE  = WOFF_W'(1);
    localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(BLOCK_WORDS - 1);

    state_e              state_q, state_d;
    logic [WOFF_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TAG_W-1:0]    req_tag_q, req_tag_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [NUM_SETS-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]    tag_q [NUM_SETS];

    logic [1:0]          cpu_lane_s;
    logic [WOFF_W-1:0]   cpu_woff_s;
    logic [IDX_W-1:0]    cpu_idx_s;
    logic [TAG_W-1:0]    cpu_tag_s;
    logic                hit_s, miss_s, store_hit_s, ack_s;
    logic                fill_we_s, fill_done_s, wb_done_s;
    logic [IDX_W-1:0]    rd_set_s;
    logic [WOFF_W-1:0]   rd_word_s;
    logic [31:0]         rd_data_s;
    logic                wr_en_s;
    logic [IDX_W-1:0]    wr_set_s;
    logic [WOFF_W-1:0]   wr_word_s;
    logic [3:0]          wr_be_s;
    logic [31:0]         wr_data_s;
    logic [31:0]         cpu_rdata_s;
    logic [7:0]          lb_byte_s;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]  tag,
                                                    input logic [IDX_W-1:0]  idx,
                                                    input logic [WOFF_W-1:0] word);
        return {tag, idx, word, 2'b00};
    endfunction

    assign cpu_lane_s  = cpu_addr[1:0];
    assign cpu_woff_s  = cpu_addr[BYTE_OFF_W +: WOFF_W];
    assign cpu_idx_s   = cpu_addr[BYTE_OFF_W + WOFF_W +: IDX_W];
    assign cpu_tag_s   = cpu_addr[ADDR_W-1 -: TAG_W];

    assign hit_s       = cpu_req && (state_q == IDLE) && valid_q[cpu_idx_s]
                         && (tag_q[cpu_idx_s] == cpu_tag_s);
    assign miss_s      = cpu_req && (state_q == IDLE) && !hit_s;
    assign store_hit_s = hit_s && cpu_we;
    assign ack_s       = mem_ack && mem_req_q;

    // Read port: CPU word while idle (word 0 on a miss to seed write-back), next victim word otherwise.
    always_comb begin
        rd_set_s  = idx_q;
        rd_word_s = cnt_q + WORD_ONE;
        if (state_q == IDLE) begin
            rd_set_s  = cpu_idx_s;
            rd_word_s = hit_s ? cpu_woff_s : WORD_ZERO;
        end else begin
            rd_set_s  = idx_q;
            rd_word_s = cnt_q + WORD_ONE;
        end
    end

    // Miss engine next-state; memory-side outputs are computed a cycle ahead and registered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        req_tag_d   = req_tag_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_we_s   = 1'b0;
        fill_done_s = 1'b0;
        wb_done_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_s) begin
                    idx_d     = cpu_idx_s;
                    req_tag_d = cpu_tag_s;
                    cnt_d     = WORD_ZERO;
                    mem_req_d = 1'b1;
                    if (valid_q[cpu_idx_s] && dirty_q[cpu_idx_s]) begin
                        state_d     = WRITEBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = line_addr(tag_q[cpu_idx_s], cpu_idx_s, WORD_ZERO);
                        mem_wdata_d = rd_data_s;
                    end else begin
                        state_d     = ALLOCATE;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = line_addr(cpu_tag_s, cpu_idx_s, WORD_ZERO);
                        mem_wdata_d = 32'h0000_0000;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                if (ack_s) begin
                    if (cnt_q == LAST_WORD) begin
                        wb_done_s   = 1'b1;
                        cnt_d       = WORD_ZERO;
                        state_d     = ALLOCATE;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = line_addr(req_tag_q, idx_q, WORD_ZERO);
                        mem_wdata_d = 32'h0000_0000;
                    end else begin
                        cnt_d       = cnt_q + WORD_ONE;
                        mem_addr_d  = line_addr(tag_q[idx_q], idx_q, cnt_q + WORD_ONE);
                        mem_wdata_d = rd_data_s;
                    end
                end else begin
                    state_d = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (ack_s) begin
                    fill_we_s = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        fill_done_s = 1'b1;
                        cnt_d       = WORD_ZERO;
                        state_d     = IDLE;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {ADDR_W{1'b0}};
                    end else begin
                        cnt_d      = cnt_q + WORD_ONE;
                        mem_addr_d = line_addr(req_tag_q, idx_q, cnt_q + WORD_ONE);
                    end
                end else begin
                    state_d = ALLOCATE;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = WORD_ZERO;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = {ADDR_W{1'b0}};
                mem_wdata_d = 32'h0000_0000;
            end
        endcase
    end

    // Write port arbitration: refill words take priority over store hits (they never coincide).
    always_comb begin
        wr_en_s   = 1'b0;
        wr_set_s  = cpu_idx_s;
        wr_word_s = cpu_woff_s;
        wr_be_s   = 4'b0000;
        wr_data_s = cpu_wdata;
        if (fill_we_s) begin
            wr_en_s   = 1'b1;
            wr_set_s  = idx_q;
            wr_word_s = cnt_q;
            wr_be_s   = 4'b1111;
            wr_data_s = mem_rdata;
        end else if (store_hit_s) begin
            wr_en_s   = 1'b1;
            wr_be_s   = cpu_byte ? lane_be(cpu_lane_s) : 4'b1111;
            wr_data_s = cpu_byte ? {4{cpu_wdata[7:0]}} : cpu_wdata;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Load data: whole word, or a sign-extended little-endian byte lane; zero when not hitting.
    always_comb begin
        cpu_rdata_s = 32'h0000_0000;
        lb_byte_s   = lane_byte(rd_data_s, cpu_lane_s);
        if (!hit_s) begin
            cpu_rdata_s = 32'h0000_0000;
        end else if (cpu_byte) begin
            cpu_rdata_s = {{24{lb_byte_s[7]}}, lb_byte_s};
        end else begin
            cpu_rdata_s = rd_data_s;
        end
    end

    // FSM and memory-interface registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= WORD_ZERO;
            idx_q       <= {IDX_W{1'b0}};
            req_tag_q   <= {TAG_W{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            req_tag_q   <= req_tag_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Line status: a missed line is invalid until its refill completes.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= {NUM_SETS{1'b0}};
            dirty_q <= {NUM_SETS{1'b0}};
        end else if (fill_done_s) begin
            valid_q[idx_q] <= 1'b1;
            dirty_q[idx_q] <= 1'b0;
        end else if (wb_done_s) begin
            dirty_q[idx_q] <= 1'b0;
        end else if (miss_s) begin
            valid_q[cpu_idx_s] <= 1'b0;
        end else if (store_hit_s) begin
            dirty_q[cpu_idx_s] <= 1'b1;
        end
    end

    // Tag store, written once the refill of a line has completed.
    always_ff @(posedge clk) begin
        if (fill_done_s) begin
            tag_q[idx_q] <= req_tag_q;
        end
    end

    dcache_data_array #(
        .NUM_SETS    (NUM_SETS),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_data (
        .clk       (clk),
        .rd_set_i  (rd_set_s),
        .rd_word_i (rd_word_s),
        .rd_data_o (rd_data_s),
        .wr_en_i   (wr_en_s),
        .wr_set_i  (wr_set_s),
        .wr_word_i (wr_word_s),
        .wr_be_i   (wr_be_s),
        .wr_data_i (wr_data_s)
    );

    assign hit       = hit_s;
    assign cpu_rdata = cpu_rdata_s;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a latency-configurable word memory responder.
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cpu_req, cpu_we, cpu_byte;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        hit, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dcache_controller #(
        .NUM_SETS    (256),
        .BLOCK_WORDS (4),
        .ADDR_W      (32)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_byte  (cpu_byte),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 0;
    int          wait_n   = 0;
    logic [31:0] bmem [0:8191];
    logic        log_we   [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        hold_we;
    logic [31:0] hold_addr, hold_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic check_xfer(input string tag, input int k, input logic we,
                              input logic [31:0] addr, input logic [31:0] data);
        if (k < log_addr.size()) begin
            check_eq($sformatf("%s_%0d_we", tag, k), {31'd0, log_we[k]}, {31'd0, we});
            check_eq($sformatf("%s_%0d_addr", tag, k), log_addr[k], addr);
            check_eq($sformatf("%s_%0d_data", tag, k), log_data[k], data);
        end else begin
            check_eq($sformatf("%s_%0d_present", tag, k), 32'(log_addr.size()), 32'(k + 1));
        end
    endtask

    // One CPU access: hold the request until hit, return miss cycles and load data.
    task automatic access(input logic we, input logic bt, input logic [31:0] addr,
                          input logic [31:0] wdata, output int cycles, output logic [31:0] rdata);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_byte = bt; cpu_addr = addr; cpu_wdata = wdata;
        #1;
        cycles = 0;
        while (hit !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check_eq($sformatf("hit_reached_%08h", addr), {31'd0, hit}, 32'd1);
        rdata = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0;
    endtask

    // Memory responder: acks each word after `lat` wait cycles, checks the request stays put.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;
        forever begin
            @(negedge clk);
            if (!rst_b || !mem_req) begin
                mem_ack = 1'b0;
                wait_n  = 0;
            end else begin
                if (mem_ack) wait_n = 0;
                if (wait_n == 0) begin
                    hold_we = mem_we; hold_addr = mem_addr; hold_wdata = mem_wdata;
                end else begin
                    check_eq("hold_addr", mem_addr, hold_addr);
                    check_eq("hold_we", {31'd0, mem_we}, {31'd0, hold_we});
                    check_eq("hold_wdata", mem_wdata, hold_wdata);
                end
                if (wait_n >= lat) begin
                    mem_ack = 1'b1;
                    log_we.push_back(mem_we);
                    log_addr.push_back(mem_addr);
                    if (mem_we) begin
                        bmem[mem_addr[14:2]] = mem_wdata;
                        log_data.push_back(mem_wdata);
                    end else begin
                        mem_rdata = bmem[mem_addr[14:2]];
                        log_data.push_back(mem_rdata);
                    end
                end else begin
                    mem_ack = 1'b0;
                    wait_n++;
                end
            end
        end
    end

    initial begin
        int          cyc;
        logic [31:0] rd;
        for (int i = 0; i < 8192; i++) bmem[i] = 32'hC0DE_0000 | 32'(i * 4);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0;
        cpu_addr = 32'h0000_0040; cpu_wdata = 32'h0000_0000;
        rst_b = 1'b1;
        #2;
        rst_b   = 1'b0;
        cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_hit", {31'd0, hit}, 32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'h0000_0000);
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0000_0000);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0000_0000);
        @(negedge clk);
        cpu_req = 1'b0;
        rst_b   = 1'b1;

        // Cold miss: four zero-wait reads, no write-back.
        lat = 0; clear_log();
        access(1'b0, 1'b0, 32'h0000_0040, 32'h0, cyc, rd);
        check_eq("lw40_cycles", 32'(cyc), 32'd5);
        check_eq("lw40_rdata", rd, 32'hC0DE_0040);
        check_eq("lw40_nxfer", 32'(log_addr.size()), 32'd4);
        check_eq("lw40_req_drop", {31'd0, mem_req}, 32'd0);
        for (int k = 0; k < 4; k++)
            check_xfer("lw40", k, 1'b0, 32'h40 + 32'(4 * k), 32'hC0DE_0040 + 32'(4 * k));

        // Store and load hits are single-cycle and touch no memory.
        clear_log();
        access(1'b1, 1'b0, 32'h0000_0044, 32'hDEAD_BEEF, cyc, rd);
        check_eq("sw44_cycles", 32'(cyc), 32'd0);
        access(1'b0, 1'b0, 32'h0000_0044, 32'h0, cyc, rd);
        check_eq("lw44_cycles", 32'(cyc), 32'd0);
        check_eq("lw44_rdata", rd, 32'hDEAD_BEEF);
        access(1'b1, 1'b1, 32'h0000_0045, 32'h1234_5680, cyc, rd);
        check_eq("sb45_cycles", 32'(cyc), 32'd0);
        access(1'b0, 1'b1, 32'h0000_0045, 32'h0, cyc, rd);
        check_eq("lb45_rdata", rd, 32'hFFFF_FF80);
        access(1'b0, 1'b0, 32'h0000_0044, 32'h0, cyc, rd);
        check_eq("lw44_merged", rd, 32'hDEAD_80EF);
        access(1'b0, 1'b1, 32'h0000_0044, 32'h0, cyc, rd);
        check_eq("lb44_rdata", rd, 32'hFFFF_FFEF);
        access(1'b0, 1'b1, 32'h0000_0047, 32'h0, cyc, rd);
        check_eq("lb47_rdata", rd, 32'hFFFF_FFDE);
        access(1'b0, 1'b1, 32'h0000_0048, 32'h0, cyc, rd);
        check_eq("lb48_rdata", rd, 32'h0000_0048);
        check_eq("hits_nxfer", 32'(log_addr.size()), 32'd0);

        // Conflict miss with a dirty victim and a slow memory.
        lat = 5; clear_log();
        access(1'b0, 1'b0, 32'h0000_4040, 32'h0, cyc, rd);
        check_eq("lw4040_cycles", 32'(cyc), 32'd49);
        check_eq("lw4040_rdata", rd, 32'hC0DE_4040);
        check_eq("lw4040_nxfer", 32'(log_addr.size()), 32'd8);
        check_xfer("wb", 0, 1'b1, 32'h0000_0040, 32'hC0DE_0040);
        check_xfer("wb", 1, 1'b1, 32'h0000_0044, 32'hDEAD_80EF);
        check_xfer("wb", 2, 1'b1, 32'h0000_0048, 32'hC0DE_0048);
        check_xfer("wb", 3, 1'b1, 32'h0000_004C, 32'hC0DE_004C);
        for (int k = 0; k < 4; k++)
            check_xfer("fill", 4 + k, 1'b0, 32'h4040 + 32'(4 * k), 32'hC0DE_4040 + 32'(4 * k));

        // The refilled line is clean: evicting it costs no write-back.
        lat = 0; clear_log();
        access(1'b0, 1'b0, 32'h0000_0044, 32'h0, cyc, rd);
        check_eq("relw44_cycles", 32'(cyc), 32'd5);
        check_eq("relw44_rdata", rd, 32'hDEAD_80EF);
        check_eq("relw44_nxfer", 32'(log_addr.size()), 32'd4);
        check_xfer("relw44", 0, 1'b0, 32'h0000_0040, 32'hC0DE_0040);

        // Reset while refilling word 2 of a line.
        lat = 2; clear_log();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h0000_0080;
        cyc = 0;
        while (log_addr.size() < 2 && cyc < 100) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check_eq("mid_acks", 32'(log_addr.size()), 32'd2);
        @(posedge clk);
        #2;
        check_eq("mid_addr", mem_addr, 32'h0000_0088);
        check_eq("mid_req", {31'd0, mem_req}, 32'd1);
        rst_b = 1'b0;
        #1;
        check_eq("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("mid_rst_addr", mem_addr, 32'h0000_0000);
        check_eq("mid_rst_hit", {31'd0, hit}, 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        lat = 0; clear_log();
        access(1'b0, 1'b0, 32'h0000_0080, 32'h0, cyc, rd);
        check_eq("relw80_cycles", 32'(cyc), 32'd5);
        check_eq("relw80_rdata", rd, 32'hC0DE_0080);
        check_eq("relw80_nxfer", 32'(log_addr.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check_xfer("relw80", k, 1'b0, 32'h80 + 32'(4 * k), 32'hC0DE_0080 + 32'(4 * k));
        access(1'b0, 1'b0, 32'h0000_0044, 32'h0, cyc, rd);
        check_eq("postrst_lw44_cycles", 32'(cyc), 32'd5);
        check_eq("postrst_lw44_rdata", rd, 32'hDEAD_80EF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate data cache that services the memory stage.
- Sits between the MEM stage and the backing word memory.
- Serves LW/LB/SW/SB requests.
- Drives `hit`, which the control unit uses to gate `pc_we`. While a memory instruction misses, `hit`=0 and the pipeline holds.
- The block completes the refill or write-back over a word-serial memory handshake, then asserts `hit` so the held instruction retires.

Parameters:
NUM_SETS, 256, number of cache lines; power of two.
BLOCK_WORDS, 4, 32-bit words per line; power of two, >=2.
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_b  in  1  asynchronous, active-low reset.
cpu_req  in  1  MEM-stage instruction is LW/LB/SW/SB.
cpu_we  in  1  1 = store (SW/SB), 0 = load.
cpu_byte  in  1  1 = byte access (LB/SB), 0 = word access.
cpu_addr  in  ADDR_W  byte address (ALU result).
cpu_wdata  in  32  store data; SB uses bits [7:0].
cpu_rdata  out  32  load data; valid when hit=1.
hit  out  1  request is satisfied this cycle.
mem_req  out  1  word transfer request to backing memory.
mem_we  out  1  1 = write-back word, 0 = refill read.
mem_addr  out  ADDR_W  word-aligned byte address of the transfer.
mem_wdata  out  32  write-back word.
mem_rdata  in  32  refill word; valid with mem_ack.
mem_ack  in  1  transfer of the current word completes at this edge.

Behaviour:
- Address split, low to high: byte offset [1:0], word offset (log2 BLOCK_WORDS), index (log2 NUM_SETS), tag (remaining bits).
- Per-line storage: valid, dirty, tag, BLOCK_WORDS data words.
- Reset (async, rst_b=0):
  - state=IDLE; all valid and dirty bits cleared; word counter=0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit=0, cpu_rdata=0.
  - Tags and data are not reset.
  - Reset mid-transfer abandons the transfer immediately; the partially filled line stays invalid.
- hit is combinational: cpu_req & state==IDLE & valid[idx] & tag match. Zero-latency hit.
- cpu_rdata is 0 whenever hit=0.
  - LW: selected word; addr[1:0] ignored.
  - LB: byte lane addr[1:0], little-endian, sign-extended to 32 bits.
- Store hit: at the clock edge with hit=1, write the word (SW) or the single byte lane addr[1:0] (SB), and set dirty. Single cycle.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
  - IDLE, cpu_req=1 and miss:
    - Capture index and tag.
    - If victim valid & dirty, go to WRITEBACK; otherwise go to ALLOCATE.
    - Counter=0.
  - WRITEBACK:
    - mem_req=1, mem_we=1, mem_addr={victim tag, idx, cnt, 2'b00}, mem_wdata=line word cnt.
    - On mem_ack, cnt++.
    - After word BLOCK_WORDS-1 is acked: clear dirty, cnt=0, go to ALLOCATE.
  - ALLOCATE:
    - mem_req=1, mem_we=0, mem_addr={req tag, idx, cnt, 2'b00}.
    - On mem_ack, write mem_rdata into word cnt, cnt++.
    - After the last ack: set valid, write tag, dirty=0, go to IDLE.
    - The next cycle hits and performs the access normally; a store then sets dirty.
- Handshake:
  - mem_req, mem_addr, mem_we and mem_wdata are registered and held stable until the mem_ack edge.
  - mem_req may stay high across consecutive words with the next address.
  - mem_req drops in the cycle after the final ack.
  - mem_ack while mem_req=0 is ignored.
- Miss penalty: 1 + transfers × memory latency; there is no fixed upper bound.
- cpu_req dropping or cpu_addr changing during a miss: the captured refill completes, then the block returns to IDLE. It is never aborted except by reset.
- A miss to the same line in the cycle after a refill is impossible: that cycle hits.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, WRITEBACK, ALLOCATE).
  - Localparam functions for the OFFSET/INDEX/TAG widths derived from the parameters.
  - Byte-lane select constants.
- Sub-module dcache_data_array:
  - NUM_SETS×BLOCK_WORDS×32 storage.
  - Async read port and one synchronous write port with a 4-bit byte enable.
  - Shared by store hits and refill writes; priority goes to refill, and the two never coincide.

Test Plan:
- Reset then LW 0x0000_0040 → hit=0; exactly 4 read transfers to 0x40, 0x44, 0x48, 0x4C, no write-back; the following cycle hit=1 and cpu_rdata = memory word 0x40.
- SW 0xDEADBEEF to 0x44 (hit), then LW 0x44 → both single-cycle hit=1; LW returns 0xDEADBEEF; memory sees no transfer.
- SB 0x80 to 0x45, then LB 0x45 → 0xFFFFFF80; LW 0x44 → 0xDEAD80EF.
- LW 0x0000_4040 (same index, new tag, dirty victim) → 4 writes (mem_we=1) to 0x40..0x4C carrying the modified data, then 4 reads from 0x4040..0x404C, then hit.
- mem_ack delayed 5 cycles per word → mem_req/mem_addr/mem_wdata held constant; hit stays 0 throughout; no counter skip.
- rst_b pulled low during ALLOCATE word 2 → mem_req=0 immediately; LW to the same address afterwards misses and re-fetches all 4 words.
